// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: state encodings,
// widths, default data-burst cap and the latched memory command payload.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned MAX_DBURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arbStateT;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wData;
  } memCmdT;

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Grant decision between instruction and data ports, with a cap on consecutive
// data grants while an instruction fetch is waiting.
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DBURST = MAX_DBURST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic iReq,
  input  logic iAck,
  input  logic dReq,
  input  logic dAck,
  output logic grantI_c,
  output logic grantD_c
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DBURST);

  logic [CNT_W-1:0] dCount;
  logic             iElig;
  logic             dElig;
  logic             decide;
  logic             capHit;

  assign iElig  = iReq & ~iAck;
  assign dElig  = dReq & ~dAck;
  // The ack cycle is a turnaround, so a held dReq is weighed against the cap
  // on the following cycle instead of losing to the waiting fetch every time.
  assign decide = idle & ~iAck & ~dAck;
  assign capHit = iElig & (dCount == MAX_CNT);

  assign grantD_c = decide & dElig & ~capHit;
  assign grantI_c = decide & iElig & ~grantD_c;

  // Data grants counted only while a fetch is pending; saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dCount <= '0;
    end else if (!iReq || grantI_c) begin
      dCount <= '0;
    end else if (grantD_c && (dCount != MAX_CNT)) begin
      dCount <= dCount + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction fetch port and
// a load/store port; FSM, request latches and return datapath.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DBURST = MAX_DBURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic [DATA_W-1:0] iData,
  output logic              iAck,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic [DATA_W-1:0] dRData,
  output logic              dAck,
  output logic              memCe,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memReady,
  output logic              stall
);

  arbStateT          state;
  arbStateT          stateNext;
  memCmdT            memCmd;
  memCmdT            memCmdNext;
  logic              memCeNext;
  logic              iAckNext;
  logic              dAckNext;
  logic [DATA_W-1:0] iDataNext;
  logic [DATA_W-1:0] dRDataNext;
  logic              grantI;
  logic              grantD;

  arb_prio #(
    .MAX_DBURST(MAX_DBURST)
  ) uPrio (
    .clk     (clk),
    .rst     (rst),
    .idle    (state == IDLE),
    .iReq    (iReq),
    .iAck    (iAck),
    .dReq    (dReq),
    .dAck    (dAck),
    .grantI_c(grantI),
    .grantD_c(grantD)
  );

  assign stall    = (iReq & ~iAck) | (dReq & ~dAck);
  assign memWe    = memCmd.we;
  assign memAddr  = memCmd.addr;
  assign memWData = memCmd.wData;

  // Next state, command latch and return data.
  always_comb begin
    stateNext  = state;
    memCmdNext = memCmd;
    memCeNext  = memCe;
    iAckNext   = 1'b0;
    dAckNext   = 1'b0;
    iDataNext  = iData;
    dRDataNext = dRData;
    unique case (state)
      IDLE: begin
        if (grantD) begin
          stateNext  = DACC;
          memCeNext  = 1'b1;
          memCmdNext = '{we: dWe, addr: dAddr, wData: dWe ? dWData : '0};
        end else if (grantI) begin
          stateNext  = IACC;
          memCeNext  = 1'b1;
          memCmdNext = '{we: 1'b0, addr: iAddr, wData: '0};
        end
      end
      IACC: begin
        if (memReady) begin
          stateNext  = IDLE;
          memCeNext  = 1'b0;
          memCmdNext = '0;
          iAckNext   = 1'b1;
          iDataNext  = memRData;
        end
      end
      DACC: begin
        if (memReady) begin
          stateNext  = IDLE;
          memCeNext  = 1'b0;
          memCmdNext = '0;
          dAckNext   = 1'b1;
          if (!memCmd.we) dRDataNext = memRData;
        end
      end
      default: begin
        stateNext  = IDLE;
        memCeNext  = 1'b0;
        memCmdNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      memCmd <= '0;
      memCe  <= 1'b0;
      iAck   <= 1'b0;
      dAck   <= 1'b0;
      iData  <= '0;
      dRData <= '0;
    end else begin
      state  <= stateNext;
      memCmd <= memCmdNext;
      memCe  <= memCeNext;
      iAck   <= iAckNext;
      dAck   <= dAckNext;
      iData  <= iDataNext;
      dRData <= dRDataNext;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, priority, burst cap, wait states
// and asynchronous reset in the middle of an access.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iReq;
  logic [31:0] iAddr;
  logic [31:0] iData;
  logic        iAck;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWData;
  logic [31:0] dRData;
  logic        dAck;
  logic        memCe;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memReady;
  logic        stall;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.MAX_DBURST(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .iReq    (iReq),
    .iAddr   (iAddr),
    .iData   (iData),
    .iAck    (iAck),
    .dReq    (dReq),
    .dWe     (dWe),
    .dAddr   (dAddr),
    .dWData  (dWData),
    .dRData  (dRData),
    .dAck    (dAck),
    .memCe   (memCe),
    .memWe   (memWe),
    .memAddr (memAddr),
    .memWData(memWData),
    .memRData(memRData),
    .memReady(memReady),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkB(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] gAddr[$];
    logic        prevCe;
    int          weCycles;
    int          ackCnt;
    int          dAckSeen;

    rst = 1'b0; iReq = 1'b0; iAddr = '0; dReq = 1'b0; dWe = 1'b0;
    dAddr = '0; dWData = '0; memRData = '0; memReady = 1'b0;

    // Reset state
    repeat (3) tick();
    chkB("rst_memCe", memCe, 1'b0);
    chkB("rst_memWe", memWe, 1'b0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memWData", memWData, 32'h0);
    chkB("rst_iAck", iAck, 1'b0);
    chkB("rst_dAck", dAck, 1'b0);
    chk("rst_iData", iData, 32'h0);
    chk("rst_dRData", dRData, 32'h0);
    chkB("rst_stall", stall, 1'b0);
    rst = 1'b1;
    tick();

    // Single fetch, zero wait states
    iReq = 1'b1; iAddr = 32'h40; memReady = 1'b1; memRData = 32'h2402000A;
    #1 chkB("fetch_stall_req", stall, 1'b1);
    tick();
    chkB("fetch_memCe", memCe, 1'b1);
    chk("fetch_memAddr", memAddr, 32'h40);
    chkB("fetch_memWe", memWe, 1'b0);
    chkB("fetch_noack_yet", iAck, 1'b0);
    tick();
    chkB("fetch_iAck", iAck, 1'b1);
    chk("fetch_iData", iData, 32'h2402000A);
    chkB("fetch_stall_ack", stall, 1'b0);
    chkB("fetch_memCe_off", memCe, 1'b0);
    iReq = 1'b0;
    tick();
    chkB("fetch_iAck_pulse", iAck, 1'b0);
    chk("fetch_iData_hold", iData, 32'h2402000A);
    chkB("idle_ready_ignored", memCe, 1'b0);

    // Simultaneous requests: data first, then instruction
    iReq = 1'b1; iAddr = 32'h44; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h100;
    memRData = 32'h11112222;
    tick();
    chkB("both_memCe", memCe, 1'b1);
    chk("both_first_addr", memAddr, 32'h100);
    tick();
    chkB("both_dAck", dAck, 1'b1);
    chk("both_dRData", dRData, 32'h11112222);
    chkB("both_stall_ipend", stall, 1'b1);
    chkB("both_iAck_early", iAck, 1'b0);
    dReq = 1'b0; memRData = 32'h33334444;
    tick();
    chkB("both_turnaround", memCe, 1'b0);
    chkB("both_stall_wait", stall, 1'b1);
    tick();
    chkB("both_second_ce", memCe, 1'b1);
    chk("both_second_addr", memAddr, 32'h44);
    tick();
    chkB("both_iAck", iAck, 1'b1);
    chk("both_iData", iData, 32'h33334444);
    chk("both_dRData_hold", dRData, 32'h11112222);
    chkB("both_stall_done", stall, 1'b0);
    iReq = 1'b0;
    tick();

    // Continuous data traffic against a waiting fetch: burst cap of 4
    memRData = 32'h55556666;
    iReq = 1'b1; iAddr = 32'h48; dReq = 1'b1; dWe = 1'b0; dAddr = 32'h300;
    prevCe = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (memCe && !prevCe) gAddr.push_back(memAddr);
      prevCe = memCe;
      if (iAck) iReq = 1'b0;
    end
    chkB("burst_grant_count", gAddr.size() >= 6, 1'b1);
    chk("burst_g0", gAddr[0], 32'h300);
    chk("burst_g1", gAddr[1], 32'h300);
    chk("burst_g2", gAddr[2], 32'h300);
    chk("burst_g3", gAddr[3], 32'h300);
    chk("burst_g4_instr", gAddr[4], 32'h48);
    chk("burst_g5_resume", gAddr[5], 32'h300);
    dReq = 1'b0;
    repeat (4) tick();
    chkB("burst_settled", memCe, 1'b0);
    chk("burst_dRData", dRData, 32'h55556666);

    // Write with three wait states
    memReady = 1'b0; memRData = 32'hBAD0BAD0;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h200; dWData = 32'hDEADBEEF;
    weCycles = 0; ackCnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (memCe && memWe && memAddr == 32'h200 && memWData == 32'hDEADBEEF) weCycles++;
      if (dAck) begin
        ackCnt++;
        dReq = 1'b0;
      end
      memReady = (weCycles >= 4);
    end
    chk("wr_we_cycles", 32'(weCycles), 32'd4);
    chk("wr_ack_count", 32'(ackCnt), 32'd1);
    chk("wr_dRData_hold", dRData, 32'h55556666);
    chkB("wr_memWe_off", memWe, 1'b0);
    chk("wr_memWData_off", memWData, 32'h0);

    // Asynchronous reset in the middle of a stalled data read
    memReady = 1'b0; memRData = 32'h77778888;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h400; iReq = 1'b1; iAddr = 32'h50;
    tick();
    chkB("rstmid_memCe_before", memCe, 1'b1);
    tick();
    #2 rst = 1'b0;
    #1;
    chkB("rstmid_memCe_now", memCe, 1'b0);
    chk("rstmid_memAddr_now", memAddr, 32'h0);
    chk("rstmid_dRData_clr", dRData, 32'h0);
    chk("rstmid_iData_clr", iData, 32'h0);
    memReady = 1'b1;
    dAckSeen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (dAck) dAckSeen++;
    end
    chk("rstmid_no_dAck", 32'(dAckSeen), 32'd0);
    #2 rst = 1'b1;
    tick();
    chkB("rstmid_regrant_ce", memCe, 1'b1);
    chk("rstmid_regrant_addr", memAddr, 32'h400);
    tick();
    chkB("rstmid_dAck", dAck, 1'b1);
    chk("rstmid_dRData", dRData, 32'h77778888);
    dReq = 1'b0; memRData = 32'h9999AAAA;
    tick();
    tick();
    chk("rstmid_igrant_addr", memAddr, 32'h50);
    tick();
    chkB("rstmid_iAck", iAck, 1'b1);
    chk("rstmid_iData", iData, 32'h9999AAAA);
    iReq = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter SHALL be: MAX_DBURST, 4, consecutive data grants allowed while an instruction request waits (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 iReq  input  1  instruction fetch request, held until iAck.
REQ-005 iAddr  input  32  fetch address, stable while iReq.
REQ-006 iData  output  32  fetched word, valid in iAck cycle.
REQ-007 iAck  output  1  one-cycle fetch completion pulse.
REQ-008 dReq  input  1  data request, held until dAck.
REQ-009 dWe  input  1  1=write, 0=read; stable while dReq.
REQ-010 dAddr  input  32  data address, stable while dReq.
REQ-011 dWData  input  32  store data, stable while dReq.
REQ-012 dRData  output  32  load data, valid in dAck cycle of a read.
REQ-013 dAck  output  1  one-cycle data completion pulse.
REQ-014 memCe  output  1  shared single-port memory enable.
REQ-015 memWe  output  1  memory write enable.
REQ-016 memAddr  output  32  memory address.
REQ-017 memWData  output  32  memory write data.
REQ-018 memRData  input  32  memory read data, valid when memReady=1.
REQ-019 memReady  input  1  memory completes current access this cycle.
REQ-020 stall  output  1  pipeline freeze = (iReq & ~iAck) | (dReq & ~dAck), combinational.

Function
REQ-021 FSM SHALL have states IDLE, IACC, DACC.
REQ-022 IDLE: eligible port = req high and its ack low this cycle; data eligible and not (iReq eligible and dCount==MAX_DBURST) -> DACC; else instruction eligible -> IACC; else stay IDLE.
REQ-023 On grant, address/we/wdata of granted port SHALL be latched; memory outputs driven from latches only.
REQ-024 In IACC/DACC: memCe=1, memAddr=latched address; memWe=1 and memWData=latched data only for DACC write; else memWe=0, memWData=0.
REQ-025 In IDLE: memCe=0, memWe=0, memAddr=0, memWData=0.
REQ-026 In access state with memReady=1: next state IDLE; iData (IACC) or dRData (DACC read) registered from memRData; corresponding ack high for exactly the next cycle.
REQ-027 memReady=0 in access state: stay, outputs unchanged (unbounded wait states).
REQ-028 Zero-wait latency: req seen in cycle N, memCe in N+1, ack in N+2; back-to-back same-port throughput one access per 3 cycles.
REQ-029 dRData SHALL hold previous value on write acks; iData/dRData hold between acks.
REQ-030 dCount (4-bit): +1 on each data grant while iReq high; cleared on instruction grant or any cycle iReq low; saturates at MAX_DBURST.
REQ-031 Requester dropping req mid-access: access SHALL complete and ack still pulse (protocol violation, not aborted).
REQ-032 memReady in IDLE SHALL be ignored.

Reset
REQ-033 rst low SHALL immediately force IDLE, iAck=dAck=0, iData=dRData=0, dCount=0, latches=0, all mem outputs 0, regardless of access in progress; no ack issued for aborted access.
REQ-034 First grant possible in first rising edge after rst deasserts.

Structure
REQ-035 State encodings and MAX_DBURST default SHALL live in shared def.v.
REQ-036 Priority/starvation logic (dCount, grant decision) SHALL be one sub-module arb_prio; FSM, latches and datapath in mem_arbiter.

Verification
REQ-037 Read only: iReq, iAddr=0x40, memReady=1 immediate, memRData=0x2402000A -> memCe cycle N+1 addr 0x40, iAck+iData=0x2402000A at N+2.
REQ-038 Simultaneous iReq and dReq (read 0x100) -> DACC first, dAck, then IACC; stall high until iAck.
REQ-039 Continuous dReq with iReq held, MAX_DBURST=4 -> exactly 4 data grants, then instruction grant, then data resumes.
REQ-040 Write dAddr=0x200, dWData=0xDEADBEEF, memReady low 3 cycles -> memWe=1 held 4 cycles, single dAck, dRData unchanged.
REQ-041 rst low mid-DACC with memReady=0 -> memCe=0 same cycle, no dAck, IDLE after release, pending reqs re-granted.
